// File: rtl/spi_flash_reader.sv
// Drives the SPI master's Wishbone register port to run SPI-flash READ (0x03)
// bursts and streams the received bytes out through a valid/ready port.
module spi_flash_reader #(
   parameter int         SEL_BIT = 0,
   parameter logic [7:0] CONF    = 8'h00,
   parameter int         LEN_W   = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req,
   input  logic [23:0]      addr,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             rd_valid,
   output logic [7:0]       rd_data,
   input  logic             rd_ready,
   output logic             m_cyc,
   output logic             m_stb,
   output logic             m_we,
   output logic [31:0]      m_adr,
   output logic [3:0]       m_sel,
   output logic [31:0]      m_dat_o,
   input  logic [31:0]      m_dat_i,
   input  logic             m_ack
);

   localparam logic [31:0]      ADR_DATA = 32'h0;
   localparam logic [31:0]      ADR_CTRL = 32'h4;
   localparam logic [7:0]       SEL_ON   = ~(8'h01 << SEL_BIT);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [2:0]       HDR_LEN  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_TX, S_POLL, S_RX, S_OUT, S_DESEL, S_FIN
   } state_t;

   state_t             state_q, state_d;
   logic [23:0]        addr_q;
   logic [LEN_W-1:0]   remain_q;
   logic [2:0]         hdr_q;
   logic [7:0]         rd_data_q;
   logic [7:0]         tx_byte;

   logic               m_cyc_q, m_we_q;
   logic [31:0]        m_adr_q, m_dat_q;
   logic [3:0]         m_sel_q;

   logic               bus_ack;
   logic               issue, iss_we;
   logic [31:0]        iss_adr, iss_dat;
   logic [3:0]         iss_sel;
   logic               accept, hdr_inc, capture, consume;

   logic               unused_dat;
   assign unused_dat = ^m_dat_i[31:8];

   // An ack only counts while a cycle is actually open.
   assign bus_ack = m_cyc_q & m_ack;

   // Command, three address bytes, then a dummy byte per data byte.
   always_comb begin
      tx_byte = 8'h00;
      case (hdr_q)
         3'd0:    tx_byte = 8'h03;
         3'd1:    tx_byte = addr_q[23:16];
         3'd2:    tx_byte = addr_q[15:8];
         3'd3:    tx_byte = addr_q[7:0];
         default: tx_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      iss_we  = 1'b0;
      iss_adr = ADR_DATA;
      iss_sel = 4'b0000;
      iss_dat = 32'h0;
      accept  = 1'b0;
      hdr_inc = 1'b0;
      capture = 1'b0;
      consume = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (len == '0) begin
                  state_d = S_FIN;
               end else begin
                  accept  = 1'b1;
                  state_d = S_SEL;
               end
            end
         end
         S_SEL: begin
            issue   = ~m_cyc_q;
            iss_we  = 1'b1;
            iss_adr = ADR_CTRL;
            iss_sel = 4'b1100;
            iss_dat = {SEL_ON, CONF, 16'h0};
            if (bus_ack) state_d = S_TX;
         end
         S_TX: begin
            issue   = ~m_cyc_q;
            iss_we  = 1'b1;
            iss_adr = ADR_DATA;
            iss_sel = 4'b0001;
            iss_dat = {24'h0, tx_byte};
            if (bus_ack) state_d = S_POLL;
         end
         S_POLL: begin
            issue   = ~m_cyc_q;
            iss_adr = ADR_CTRL;
            iss_sel = 4'b0001;
            if (bus_ack && !m_dat_i[1]) state_d = S_RX;
         end
         S_RX: begin
            issue   = ~m_cyc_q;
            iss_adr = ADR_DATA;
            iss_sel = 4'b0001;
            if (bus_ack) begin
               if (hdr_q != HDR_LEN) begin
                  hdr_inc = 1'b1;
                  state_d = S_TX;
               end else begin
                  capture = 1'b1;
                  state_d = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (rd_ready) begin
               consume = 1'b1;
               state_d = (remain_q == LEN_ONE) ? S_DESEL : S_TX;
            end
         end
         S_DESEL: begin
            issue   = ~m_cyc_q;
            iss_we  = 1'b1;
            iss_adr = ADR_CTRL;
            iss_sel = 4'b1000;
            iss_dat = {8'hFF, 24'h0};
            if (bus_ack) state_d = S_FIN;
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         addr_q    <= '0;
         remain_q  <= '0;
         hdr_q     <= '0;
         rd_data_q <= '0;
      end else begin
         if (accept) begin
            addr_q   <= addr;
            remain_q <= len;
            hdr_q    <= '0;
         end
         if (hdr_inc) hdr_q     <= hdr_q + 3'd1;
         if (capture) rd_data_q <= m_dat_i[7:0];
         if (consume) remain_q  <= remain_q - LEN_ONE;
      end
   end

   // A cycle closes on the edge that samples ack, so re-issuing from a state
   // only when cyc is low guarantees one idle cycle between bus cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         m_cyc_q <= 1'b0;
         m_we_q  <= 1'b0;
         m_adr_q <= '0;
         m_sel_q <= '0;
         m_dat_q <= '0;
      end else if (issue) begin
         m_cyc_q <= 1'b1;
         m_we_q  <= iss_we;
         m_adr_q <= iss_adr;
         m_sel_q <= iss_sel;
         m_dat_q <= iss_dat;
      end else if (bus_ack) begin
         m_cyc_q <= 1'b0;
         m_we_q  <= 1'b0;
         m_adr_q <= '0;
         m_sel_q <= '0;
         m_dat_q <= '0;
      end
   end

   assign busy     = (state_q != S_IDLE) && (state_q != S_FIN);
   assign done     = (state_q == S_FIN);
   assign rd_valid = (state_q == S_OUT);
   assign rd_data  = rd_data_q;
   assign m_cyc    = m_cyc_q;
   assign m_stb    = m_cyc_q;
   assign m_we     = m_we_q;
   assign m_adr    = m_adr_q;
   assign m_sel    = m_sel_q;
   assign m_dat_o  = m_dat_q;

endmodule
